// File: rtl/vga_frame_scanout_if.sv
// Plotter pixel-write bus: one pixel (x, y, colour) per cycle while iPlot is high.
`timescale 1ns/1ps
interface vga_frame_scanout_if;
    logic [7:0] iX;
    logic [6:0] iY;
    logic [2:0] iColour;
    logic       iPlot;

    modport master (output iX, iY, iColour, iPlot);
    modport slave  (input  iX, iY, iColour, iPlot);
endinterface

// File: rtl/vga_frame_scanout.sv
// 160x120x3 frame buffer written by the plotter and scanned out as 640x480 VGA,
// each stored pixel replicated into a block of display pixels.
`timescale 1ns/1ps
module vga_frame_scanout #(
    parameter logic [7:0]  X_SCREEN_PIXELS = 8'd160,
    parameter logic [6:0]  Y_SCREEN_PIXELS = 7'd120,
    parameter int unsigned SCALE_SHIFT     = 2,
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33
) (
    input  logic                      iClock,
    input  logic                      iResetn,
    vga_frame_scanout_if.slave        plot,
    output logic [7:0]                oVGA_R,
    output logic [7:0]                oVGA_G,
    output logic [7:0]                oVGA_B,
    output logic                      oVGA_HS,
    output logic                      oVGA_VS,
    output logic                      oVGA_BLANK_N,
    output logic                      oFrameStart
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned FB_DEPTH = int'(X_SCREEN_PIXELS) * int'(Y_SCREEN_PIXELS);
    localparam int unsigned ADDR_W   = $clog2(FB_DEPTH);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_END  = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0] HS_BEGIN   = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] HS_END     = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS_END  = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0] VS_BEGIN   = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] VS_END     = V_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [H_W-1:0]    hcount;
    logic [V_W-1:0]    vcount;
    logic              visible;
    logic              hsync_n;
    logic              vsync_n;
    logic              frame_first;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic [2:0]        frame_mem [FB_DEPTH];
    logic [2:0]        rd_colour;
    logic              blank_n_d1;
    logic              hs_d1;
    logic              vs_d1;
    logic              fs_d1;

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + V_W'(1);
        end else begin
            hcount <= hcount + H_W'(1);
        end
    end

    always_comb begin
        visible     = (hcount < H_VIS_END) && (vcount < V_VIS_END);
        hsync_n     = !((hcount >= HS_BEGIN) && (hcount < HS_END));
        vsync_n     = !((vcount >= VS_BEGIN) && (vcount < VS_END));
        frame_first = (hcount == '0) && (vcount == '0);
        rd_addr     = ADDR_W'(vcount >> SCALE_SHIFT) * ADDR_W'(X_SCREEN_PIXELS)
                    + ADDR_W'(hcount >> SCALE_SHIFT);
        wr_addr     = ADDR_W'(plot.iY) * ADDR_W'(X_SCREEN_PIXELS) + ADDR_W'(plot.iX);
        wr_en       = plot.iPlot && (plot.iX < X_SCREEN_PIXELS) && (plot.iY < Y_SCREEN_PIXELS);
    end

    // Buffer is never reset; a read colliding with a write returns the old word.
    always_ff @(posedge iClock) begin
        if (wr_en) begin
            frame_mem[wr_addr] <= plot.iColour;
        end
        if (visible) begin
            rd_colour <= frame_mem[rd_addr];
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            blank_n_d1 <= 1'b0;
            hs_d1      <= 1'b1;
            vs_d1      <= 1'b1;
            fs_d1      <= 1'b0;
        end else begin
            blank_n_d1 <= visible;
            hs_d1      <= hsync_n;
            vs_d1      <= vsync_n;
            fs_d1      <= frame_first;
        end
    end

    // rd_colour is stale outside the visible region, so blanking gates it here.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_N <= 1'b0;
            oFrameStart  <= 1'b0;
        end else begin
            oVGA_R       <= {8{blank_n_d1 & rd_colour[2]}};
            oVGA_G       <= {8{blank_n_d1 & rd_colour[1]}};
            oVGA_B       <= {8{blank_n_d1 & rd_colour[0]}};
            oVGA_HS      <= hs_d1;
            oVGA_VS      <= vs_d1;
            oVGA_BLANK_N <= blank_n_d1;
            oFrameStart  <= fs_d1;
        end
    end

endmodule
